// File: rtl/ysyx_23060184_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to single-slave AXI4-Lite arbiter.
// Holds the grant until the response handshake or a watchdog abort.
module ysyx_23060184_axi_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ACERR_WIDTH    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ifu_req,
  input  logic                   lsu_req,
  output logic                   ifu_grant,
  output logic                   lsu_grant,
  output logic                   ifu_done,
  output logic                   lsu_done,
  output logic                   access_fault,
  input  logic                   ifu_arvalid,
  input  logic [DATA_WIDTH-1:0]  ifu_araddr,
  input  logic [2:0]             ifu_arsize,
  input  logic                   ifu_rready,
  output logic                   ifu_arready,
  output logic                   ifu_rvalid,
  output logic [DATA_WIDTH-1:0]  ifu_rdata,
  output logic [ACERR_WIDTH-1:0] ifu_rresp,
  input  logic                   lsu_arvalid,
  input  logic [DATA_WIDTH-1:0]  lsu_araddr,
  input  logic [2:0]             lsu_arsize,
  input  logic                   lsu_rready,
  input  logic                   lsu_awvalid,
  input  logic [DATA_WIDTH-1:0]  lsu_awaddr,
  input  logic [2:0]             lsu_awsize,
  input  logic                   lsu_wvalid,
  input  logic [DATA_WIDTH-1:0]  lsu_wdata,
  input  logic [3:0]             lsu_wstrb,
  input  logic                   lsu_wlast,
  input  logic                   lsu_bready,
  output logic                   lsu_arready,
  output logic                   lsu_rvalid,
  output logic [DATA_WIDTH-1:0]  lsu_rdata,
  output logic [ACERR_WIDTH-1:0] lsu_rresp,
  output logic                   lsu_awready,
  output logic                   lsu_wready,
  output logic                   lsu_bvalid,
  output logic [ACERR_WIDTH-1:0] lsu_bresp,
  output logic                   soc_arvalid,
  output logic [DATA_WIDTH-1:0]  soc_araddr,
  output logic [2:0]             soc_arsize,
  output logic                   soc_rready,
  output logic                   soc_awvalid,
  output logic [DATA_WIDTH-1:0]  soc_awaddr,
  output logic [2:0]             soc_awsize,
  output logic                   soc_wvalid,
  output logic [DATA_WIDTH-1:0]  soc_wdata,
  output logic [3:0]             soc_wstrb,
  output logic                   soc_wlast,
  output logic                   soc_bready,
  input  logic                   soc_arready,
  input  logic                   soc_rvalid,
  input  logic [DATA_WIDTH-1:0]  soc_rdata,
  input  logic [ACERR_WIDTH-1:0] soc_rresp,
  input  logic                   soc_rlast,
  input  logic                   soc_awready,
  input  logic                   soc_wready,
  input  logic                   soc_bvalid,
  input  logic [ACERR_WIDTH-1:0] soc_bresp
);

  localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IFU = 2'd1,
    GNT_LSU = 2'd2
  } state_t;

  state_t              state_r, state_next_s;
  logic                last_r, last_next_s;   // 1'b0 = IFU, 1'b1 = LSU
  logic [WDOG_W-1:0]   wdog_r, wdog_next_s;
  logic                ifu_grant_r, lsu_grant_r;
  logic                granted_s, complete_s, timeout_s;
  logic                rlast_unused_s;

  // Single-beat transfers only, so rlast carries no information.
  assign rlast_unused_s = soc_rlast;

  assign granted_s  = (state_r == GNT_IFU) || (state_r == GNT_LSU);
  assign complete_s = granted_s && ((soc_rvalid && soc_rready) || (soc_bvalid && soc_bready));
  assign timeout_s  = granted_s && !complete_s && (wdog_r == WDOG_LIMIT);

  assign ifu_done     = (state_r == GNT_IFU) && (complete_s || timeout_s);
  assign lsu_done     = (state_r == GNT_LSU) && (complete_s || timeout_s);
  assign access_fault = timeout_s;
  assign ifu_grant    = ifu_grant_r;
  assign lsu_grant    = lsu_grant_r;

  // State, round-robin pointer, watchdog and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      last_r      <= 1'b0;
      wdog_r      <= '0;
      ifu_grant_r <= 1'b0;
      lsu_grant_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      last_r      <= last_next_s;
      wdog_r      <= wdog_next_s;
      ifu_grant_r <= (state_next_s == GNT_IFU);
      lsu_grant_r <= (state_next_s == GNT_LSU);
    end
  end

  // Next-state: arbitration in IDLE, release on completion or abort.
  always_comb begin
    state_next_s = state_r;
    last_next_s  = last_r;
    wdog_next_s  = wdog_r;
    case (state_r)
      IDLE: begin
        wdog_next_s = '0;
        if (ifu_req && lsu_req) begin
          state_next_s = last_r ? GNT_IFU : GNT_LSU;
        end else if (ifu_req) begin
          state_next_s = GNT_IFU;
        end else if (lsu_req) begin
          state_next_s = GNT_LSU;
        end else begin
          state_next_s = IDLE;
        end
      end
      GNT_IFU, GNT_LSU: begin
        if (complete_s || timeout_s) begin
          state_next_s = IDLE;
          last_next_s  = (state_r == GNT_LSU);
          wdog_next_s  = '0;
        end else begin
          wdog_next_s  = wdog_r + WDOG_W'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
        wdog_next_s  = '0;
      end
    endcase
  end

  // Zero-latency channel steering; everything not owned reads as zero.
  always_comb begin
    soc_arvalid = 1'b0;
    soc_araddr  = '0;
    soc_arsize  = 3'd0;
    soc_rready  = 1'b0;
    soc_awvalid = 1'b0;
    soc_awaddr  = '0;
    soc_awsize  = 3'd0;
    soc_wvalid  = 1'b0;
    soc_wdata   = '0;
    soc_wstrb   = 4'd0;
    soc_wlast   = 1'b0;
    soc_bready  = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = '0;
    case (state_r)
      GNT_IFU: begin
        soc_arvalid = ifu_arvalid;
        soc_araddr  = ifu_araddr;
        soc_arsize  = ifu_arsize;
        soc_rready  = ifu_rready;
        ifu_arready = soc_arready;
        ifu_rvalid  = soc_rvalid;
        ifu_rdata   = soc_rdata;
        ifu_rresp   = soc_rresp;
      end
      GNT_LSU: begin
        soc_arvalid = lsu_arvalid;
        soc_araddr  = lsu_araddr;
        soc_arsize  = lsu_arsize;
        soc_rready  = lsu_rready;
        soc_awvalid = lsu_awvalid;
        soc_awaddr  = lsu_awaddr;
        soc_awsize  = lsu_awsize;
        soc_wvalid  = lsu_wvalid;
        soc_wdata   = lsu_wdata;
        soc_wstrb   = lsu_wstrb;
        soc_wlast   = lsu_wlast;
        soc_bready  = lsu_bready;
        lsu_arready = soc_arready;
        lsu_rvalid  = soc_rvalid;
        lsu_rdata   = soc_rdata;
        lsu_rresp   = soc_rresp;
        lsu_awready = soc_awready;
        lsu_wready  = soc_wready;
        lsu_bvalid  = soc_bvalid;
        lsu_bresp   = soc_bresp;
      end
      default: begin
        soc_arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060184_axi_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a
// bus-ownership reference model (owner, round-robin preference, granted age).
module tb_ysyx_23060184_axi_arbiter;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic ifu_req, lsu_req, ifu_grant, lsu_grant, ifu_done, lsu_done, access_fault;
  logic ifu_arvalid, ifu_rready, ifu_arready, ifu_rvalid;
  logic [DW-1:0] ifu_araddr, ifu_rdata;
  logic [2:0] ifu_arsize;
  logic [EW-1:0] ifu_rresp;
  logic lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_wlast, lsu_bready;
  logic [DW-1:0] lsu_araddr, lsu_awaddr, lsu_wdata, lsu_rdata;
  logic [2:0] lsu_arsize, lsu_awsize;
  logic [3:0] lsu_wstrb;
  logic lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
  logic [EW-1:0] lsu_rresp, lsu_bresp;
  logic soc_arvalid, soc_rready, soc_awvalid, soc_wvalid, soc_wlast, soc_bready;
  logic [DW-1:0] soc_araddr, soc_awaddr, soc_wdata, soc_rdata;
  logic [2:0] soc_arsize, soc_awsize;
  logic [3:0] soc_wstrb;
  logic soc_arready, soc_rvalid, soc_rlast, soc_awready, soc_wready, soc_bvalid;
  logic [EW-1:0] soc_rresp, soc_bresp;

  ysyx_23060184_axi_arbiter #(.DATA_WIDTH(DW), .ACERR_WIDTH(EW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ifu_req(ifu_req), .lsu_req(lsu_req),
    .ifu_grant(ifu_grant), .lsu_grant(lsu_grant), .ifu_done(ifu_done), .lsu_done(lsu_done),
    .access_fault(access_fault),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_rready(ifu_rready),
    .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize), .lsu_wvalid(lsu_wvalid),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_bready(lsu_bready),
    .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_awready(lsu_awready), .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp),
    .soc_arvalid(soc_arvalid), .soc_araddr(soc_araddr), .soc_arsize(soc_arsize), .soc_rready(soc_rready),
    .soc_awvalid(soc_awvalid), .soc_awaddr(soc_awaddr), .soc_awsize(soc_awsize), .soc_wvalid(soc_wvalid),
    .soc_wdata(soc_wdata), .soc_wstrb(soc_wstrb), .soc_wlast(soc_wlast), .soc_bready(soc_bready),
    .soc_arready(soc_arready), .soc_rvalid(soc_rvalid), .soc_rdata(soc_rdata), .soc_rresp(soc_rresp),
    .soc_rlast(soc_rlast), .soc_awready(soc_awready), .soc_wready(soc_wready), .soc_bvalid(soc_bvalid),
    .soc_bresp(soc_bresp)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  // Reference model: owner 0 = nobody, 1 = IFU, 2 = LSU; pref_last = last served.
  int m_owner = 0;
  int m_last  = 1;
  int m_age   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_complete();
    return (m_owner == 1 && soc_rvalid && ifu_rready) ||
           (m_owner == 2 && ((soc_rvalid && lsu_rready) || (soc_bvalid && lsu_bready)));
  endfunction

  task automatic model_check();
    bit gi, gl, cmp, abt;
    gi  = (m_owner == 1);
    gl  = (m_owner == 2);
    cmp = m_complete();
    abt = (m_owner != 0) && !cmp && (m_age + 1 == TO);
    chk("ifu_grant", ifu_grant, gi);
    chk("lsu_grant", lsu_grant, gl);
    chk("ifu_done", ifu_done, gi && (cmp || abt));
    chk("lsu_done", lsu_done, gl && (cmp || abt));
    chk("access_fault", access_fault, abt);
    chk("soc_arvalid", soc_arvalid, gi ? ifu_arvalid : (gl ? lsu_arvalid : 1'b0));
    chk("soc_rready", soc_rready, gi ? ifu_rready : (gl ? lsu_rready : 1'b0));
    chk("soc_awvalid", soc_awvalid, gl ? lsu_awvalid : 1'b0);
    chk("soc_wvalid", soc_wvalid, gl ? lsu_wvalid : 1'b0);
    chk("soc_bready", soc_bready, gl ? lsu_bready : 1'b0);
    if (gi) begin
      chk("soc_araddr_ifu", soc_araddr, ifu_araddr);
      chk("soc_arsize_ifu", soc_arsize, ifu_arsize);
    end
    if (gl) begin
      chk("soc_araddr_lsu", soc_araddr, lsu_araddr);
      chk("soc_aw_lsu", {soc_awaddr, soc_awsize}, {lsu_awaddr, lsu_awsize});
      chk("soc_w_lsu", {soc_wdata, soc_wstrb, soc_wlast}, {lsu_wdata, lsu_wstrb, lsu_wlast});
    end
    chk("ifu_arready", ifu_arready, gi ? soc_arready : 1'b0);
    chk("ifu_rvalid", ifu_rvalid, gi ? soc_rvalid : 1'b0);
    chk("ifu_rdata", ifu_rdata, gi ? soc_rdata : 32'd0);
    chk("ifu_rresp", ifu_rresp, gi ? soc_rresp : 2'd0);
    chk("lsu_arready", lsu_arready, gl ? soc_arready : 1'b0);
    chk("lsu_rvalid", lsu_rvalid, gl ? soc_rvalid : 1'b0);
    chk("lsu_rdata", lsu_rdata, gl ? soc_rdata : 32'd0);
    chk("lsu_rresp", lsu_rresp, gl ? soc_rresp : 2'd0);
    chk("lsu_awready", lsu_awready, gl ? soc_awready : 1'b0);
    chk("lsu_wready", lsu_wready, gl ? soc_wready : 1'b0);
    chk("lsu_bvalid", lsu_bvalid, gl ? soc_bvalid : 1'b0);
    chk("lsu_bresp", lsu_bresp, gl ? soc_bresp : 2'd0);
  endtask

  task automatic model_update();
    bit cmp, abt;
    if (rst) begin
      m_owner = 0; m_last = 1; m_age = 0;
    end else if (m_owner == 0) begin
      m_age = 0;
      if (ifu_req && lsu_req) m_owner = (m_last == 1) ? 2 : 1;
      else if (ifu_req)       m_owner = 1;
      else if (lsu_req)       m_owner = 2;
    end else begin
      cmp = m_complete();
      abt = !cmp && (m_age + 1 == TO);
      if (cmp || abt) begin
        m_last = m_owner; m_owner = 0; m_age = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic settle(); @(negedge clk); model_check(); endtask
  task automatic adv();    model_update(); @(posedge clk); #1; endtask
  task automatic cyc();    settle(); adv(); endtask

  task automatic clear_inputs();
    ifu_req = 0; lsu_req = 0;
    ifu_arvalid = 0; ifu_araddr = '0; ifu_arsize = '0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_arsize = '0; lsu_rready = 0;
    lsu_awvalid = 0; lsu_awaddr = '0; lsu_awsize = '0; lsu_wvalid = 0;
    lsu_wdata = '0; lsu_wstrb = '0; lsu_wlast = 0; lsu_bready = 0;
    soc_arready = 0; soc_rvalid = 0; soc_rdata = '0; soc_rresp = '0; soc_rlast = 0;
    soc_awready = 0; soc_wready = 0; soc_bvalid = 0; soc_bresp = '0;
  endtask

  task automatic rst_cycle();
    clear_inputs(); rst = 1; cyc(); rst = 0;
  endtask

  task automatic randomize_inputs();
    ifu_req = 1'($urandom); lsu_req = 1'($urandom);
    ifu_arvalid = 1'($urandom); ifu_araddr = $urandom; ifu_arsize = 3'($urandom);
    ifu_rready = ($urandom % 4) != 0;
    lsu_arvalid = 1'($urandom); lsu_araddr = $urandom; lsu_arsize = 3'($urandom);
    lsu_rready = ($urandom % 4) != 0;
    lsu_awvalid = 1'($urandom); lsu_awaddr = $urandom; lsu_awsize = 3'($urandom);
    lsu_wvalid = 1'($urandom); lsu_wdata = $urandom; lsu_wstrb = 4'($urandom);
    lsu_wlast = 1'($urandom); lsu_bready = ($urandom % 4) != 0;
    soc_arready = 1'($urandom); soc_rvalid = ($urandom % 5) == 0; soc_rdata = $urandom;
    soc_rresp = 2'($urandom); soc_rlast = 1'($urandom);
    soc_awready = 1'($urandom); soc_wready = 1'($urandom);
    soc_bvalid = ($urandom % 5) == 0; soc_bresp = 2'($urandom);
    rst = ($urandom % 128) == 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    settle();
    chk("reset_grants", {ifu_grant, lsu_grant}, 2'b00);
    chk("reset_soc_vr", {soc_arvalid, soc_rready, soc_awvalid, soc_wvalid, soc_bready}, 5'd0);
    chk("reset_pulses", {ifu_done, lsu_done, access_fault}, 3'd0);
    adv();

    // Single IFU read
    ifu_req = 1; ifu_araddr = 32'h3000_0000; ifu_arsize = 3'd2; ifu_rready = 1;
    for (int c = 0; c <= 5; c++) begin
      ifu_arvalid = (c <= 2);
      soc_arready = (c == 2);
      soc_rvalid  = (c == 4);
      soc_rdata   = (c == 4) ? 32'hDEAD_BEEF : 32'd0;
      if (c == 4) ifu_req = 0;
      settle();
      chk("ifu_read_grant", ifu_grant, (c >= 1) && (c <= 4));
      chk("ifu_read_done", ifu_done, c == 4);
      if (c == 4) chk("ifu_read_rdata", ifu_rdata, 32'hDEAD_BEEF);
      adv();
    end

    // Tie from reset: LSU, IFU, LSU, IFU, one idle cycle between
    rst_cycle();
    ifu_req = 1; lsu_req = 1; ifu_rready = 1; lsu_rready = 1;
    for (int c = 0; c < 16; c++) begin
      soc_rvalid = (c % 4) == 3;
      settle();
      chk("tie_lsu_grant", lsu_grant, ((c >= 1) && (c <= 3)) || ((c >= 9) && (c <= 11)));
      chk("tie_ifu_grant", ifu_grant, ((c >= 5) && (c <= 7)) || ((c >= 13) && (c <= 15)));
      adv();
    end
    clear_inputs();
    cyc();

    // LSU byte write with IFU request arriving mid-write
    lsu_awvalid = 1; lsu_awaddr = 32'h0F00_0001; lsu_awsize = 3'd0;
    lsu_wvalid = 1; lsu_wdata = 32'h0000_AB00; lsu_wstrb = 4'b0010; lsu_wlast = 1; lsu_bready = 1;
    for (int c = 0; c <= 6; c++) begin
      lsu_req = (c < 3);
      soc_awready = (c == 1); soc_wready = (c == 1);
      if (c == 2) begin
        lsu_awvalid = 0; lsu_wvalid = 0;
        ifu_arvalid = 1; ifu_araddr = $urandom; ifu_rready = 1;
      end
      ifu_req = (c >= 2) && (c < 6);
      soc_bvalid = (c == 3);
      soc_rvalid = (c == 6);
      settle();
      if (c == 1) begin
        chk("wr_soc_aw", {soc_awvalid, soc_awaddr}, {1'b1, 32'h0F00_0001});
        chk("wr_soc_w", {soc_wvalid, soc_wdata, soc_wstrb}, {1'b1, 32'h0000_AB00, 4'b0010});
      end
      chk("wr_lsu_done", lsu_done, c == 3);
      chk("wr_ifu_wait", ifu_grant, c >= 5);
      adv();
    end
    clear_inputs();
    cyc();

    // Watchdog: SoC never answers the LSU read
    rst_cycle();
    lsu_arvalid = 1; lsu_araddr = $urandom; lsu_rready = 1; soc_arready = 1;
    for (int c = 0; c <= 10; c++) begin
      lsu_req = (c < 2);
      soc_rvalid = (c >= 9);
      settle();
      chk("wdog_fault", access_fault, c == 8);
      chk("wdog_done", lsu_done, c == 8);
      chk("wdog_grant", lsu_grant, (c >= 1) && (c <= 8));
      if (c >= 9) chk("wdog_late_rvalid", {lsu_rvalid, soc_rready}, 2'b00);
      adv();
    end
    clear_inputs();

    // Reset while the IFU holds the bus
    ifu_req = 1; ifu_arvalid = 1; ifu_araddr = $urandom;
    for (int c = 0; c <= 5; c++) begin
      rst = (c == 2);
      if (c == 3) lsu_req = 1;
      if (c == 5) begin
        ifu_req = 0; lsu_req = 0; lsu_rready = 1; soc_rvalid = 1;
      end
      settle();
      if (c == 1) chk("rst_mid_arvalid_before", soc_arvalid, 1'b1);
      if (c == 3) begin
        chk("rst_mid_grants", {ifu_grant, lsu_grant}, 2'b00);
        chk("rst_mid_arvalid_after", soc_arvalid, 1'b0);
      end
      if (c == 4) chk("rst_mid_tie_lsu", {ifu_grant, lsu_grant}, 2'b01);
      adv();
    end
    rst = 0;
    clear_inputs();
    cyc();

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs();
      cyc();
    end
    rst = 0;
    clear_inputs();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_axi_arbiter.md
# ysyx_23060184_axi_arbiter

Two-master, single-slave AXI4-Lite-style arbiter sitting directly upstream of the SoC memory-access stage and the SoC AXI master port. It grants the shared bus to either the instruction fetch unit (IFU, read-only) or the load/store unit (LSU, read/write). It forwards the winner's channels unchanged and holds the grant until the transaction's response handshake completes. A watchdog aborts transactions that never receive a response.

## Interface
Parameters:
- DATA_WIDTH, 32, address/data width
- ACERR_WIDTH, 2, rresp/bresp width
- TIMEOUT_CYCLES, 1023, granted cycles without completion before abort; must be ≥ 2

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- ifu_req / lsu_req  in  1  bus request, level
- ifu_grant / lsu_grant  out  1  registered grant; one-hot or zero
- ifu_done / lsu_done  out  1  one-cycle pulse on transaction completion or abort
- access_fault  out  1  one-cycle pulse when the watchdog aborts
- ifu_arvalid, ifu_araddr[DATA_WIDTH], ifu_arsize[3], ifu_rready  in  IFU AR/R master side
- ifu_arready, ifu_rvalid, ifu_rdata[DATA_WIDTH], ifu_rresp[ACERR_WIDTH]  out  IFU AR/R returns
- lsu_arvalid, lsu_araddr, lsu_arsize, lsu_rready, lsu_awvalid, lsu_awaddr, lsu_awsize, lsu_wvalid, lsu_wdata, lsu_wstrb[4], lsu_wlast, lsu_bready  in  LSU master side
- lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp, lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp  out  LSU returns
- soc_ar*/aw*/w*/bready  out  forwarded master channels to SoC; soc_arready, soc_r*, soc_awready, soc_wready, soc_b*  in  SoC returns

## Operation
- States: IDLE, GNT_IFU, GNT_LSU. Registers: state, last (last granted master), wdog counter.
- IDLE:
  - Only one request asserted: grant that master.
  - Both asserted: grant the master that is not `last`. `last` resets to IFU, so LSU wins the first tie.
  - Neither asserted: stay in IDLE.
- While GNT_x:
  - All master→SoC signals of x are forwarded combinationally to soc_*.
  - All SoC→master return signals are forwarded to x.
  - The non-granted master sees every valid/ready return at 0 and data at 0.
- In IDLE, all soc_* valids and readies are 0.
- Completion:
  - Read completes on soc_rvalid && soc_rready.
  - Write completes on soc_bvalid && soc_bready (LSU only).
  - Single-beat only; soc_rlast is ignored.
  - On completion, state → IDLE, last ← x, and done_x pulses in the same cycle as the handshake (combinational).
- Deasserting a request while granted is ignored; the grant holds until completion or abort.
- IFU aw/w channels are tied off: soc_awvalid and soc_wvalid are 0 during GNT_IFU.
- Watchdog:
  - wdog clears on entry to GNT_x and increments each granted cycle without completion.
  - When wdog == TIMEOUT_CYCLES − 1 with no completion: state → IDLE, done_x and access_fault pulse, last ← x.
  - A late SoC response after abort is dropped: in IDLE, soc_rready and soc_bready are 0.

## Timing
- Reset values:
  - state IDLE, last IFU, wdog 0
  - all grants 0, all done pulses 0, access_fault 0
  - all soc_* valids/readies 0
- Reset mid-transaction: the next cycle is IDLE with outputs at reset values.
- Grant latency: request seen in IDLE at cycle N → grant high from N+1.
- Completion handshake at cycle C: grant low at C+1 (IDLE); earliest next grant at C+2.
- Forwarding adds zero latency; the arbiter itself never stalls a granted handshake.
- Grant registers are the only state-driven outputs. done and access_fault are combinational from the state, handshake, and wdog.

## Test plan
- Single IFU read:
  - Stimulus: ifu_req at cycle 0, araddr=0x3000_0000; SoC arready at cycle 2, rvalid with rdata=0xDEADBEEF at cycle 4.
  - Response: ifu_grant 1..4, ifu_rdata=0xDEADBEEF, ifu_done pulse at 4, grant 0 at 5.
- Tie, round-robin:
  - Stimulus: both requests held continuously from reset, each transaction 3 cycles.
  - Response: grant order LSU, IFU, LSU, IFU with a one-cycle IDLE gap between grants.
- LSU byte write:
  - Stimulus: awaddr=0x0F00_0001, wstrb=4'b0010, wdata=0x0000_AB00.
  - Response: soc_* mirrors LSU values exactly; lsu_done on the bvalid&&bready cycle; IFU request raised mid-write waits until 2 cycles after completion.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=8, LSU read, SoC never asserts rvalid.
  - Response: access_fault and lsu_done pulse on the 8th granted cycle, IDLE next; later soc_rvalid is not propagated to lsu_rvalid.
- Reset mid-read:
  - Stimulus: rst pulsed one cycle while GNT_IFU with soc_arvalid=1.
  - Response: the cycle after reset, all grants 0, soc_arvalid=0, and the next tie grants LSU.
